counter_param: RTL and testbench
================================

# counter_param

Parametrised up/down counter for board-level lab designs, generalising the fixed 8-bit enable-gated counter. Width, modulus and overflow behaviour are configurable. Adds direction control, synchronous load, wrap or saturate modes, a registered terminal-count pulse and a sticky overflow flag. It sits between the keypad/input logic, which drives `en`, and the display or LED drivers, which consume `count`.

## Interface

Parameters:
- `WIDTH`, default 8: counter width in bits; must be at least 2.
- `MAX_VAL`, default 2**WIDTH-1: top count value; the counter range is 0..MAX_VAL; must be at most 2**WIDTH-1.
- `PRESCALE`, default 1: clock cycles per count step; must be at least 1; only used when `COUNTER_PRESCALER_EN` is defined.

Ports:
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `en` input 1: count enable, active-high; the counter holds when low.
- `up_dn` input 1: direction; 1 counts up, 0 counts down.
- `sat_mode` input 1: 1 saturates at the limits, 0 wraps.
- `load` input 1: synchronous load strobe.
- `load_val` input WIDTH: load value.
- `clear_ovf` input 1: clears the sticky `ovf` flag.
- `count` output WIDTH: current count, registered.
- `tc` output 1: terminal-count pulse, one cycle, registered.
- `ovf` output 1: sticky overflow/underflow flag, registered.

## Operation

- Reset (`rst`=1, asynchronous): `count`=0, `tc`=0, `ovf`=0, prescaler=0. Takes effect immediately, including mid-count or mid-load.
- Priority per cycle: `rst` > `load` > step > hold.
- Load (`load`=1): `count` <= min(`load_val`, MAX_VAL). `tc` goes to 0. `ovf` is unchanged except for any `clear_ovf` in the same cycle. The prescaler clears. Load works regardless of `en`.
- Step occurs when `en`=1, `load`=0 and the prescaler tick is true. The tick is always true when prescaling is compiled out.
- Counting up, below MAX_VAL: `count`+1.
- Counting up, at MAX_VAL: `tc` asserts and `ovf` sets. `count` goes to 0 when `sat_mode`=0, or stays at MAX_VAL when `sat_mode`=1.
- Counting down, above 0: `count`-1.
- Counting down, at 0: `tc` asserts and `ovf` sets. `count` goes to MAX_VAL when `sat_mode`=0, or stays at 0 when `sat_mode`=1.
- `tc` asserts on every boundary step, including repeated boundary steps while saturated. It is 0 in all other cycles.
- `ovf` stays at 1 until `clear_ovf`=1 or `rst`. If a set and `clear_ovf` happen in the same cycle, the set wins.
- Hold (`en`=0, `load`=0): `count` and `ovf` hold, `tc`=0, and the prescaler holds.
- `up_dn` and `sat_mode` are sampled on each step. Changing them between steps is legal and takes effect on the next step.
- A `count` above MAX_VAL is unreachable, because loads are clamped.

## Timing

- All outputs update on the rising edge of `clk`, with one cycle of latency from sampled inputs.
- `tc` is high in the same cycle that `count` shows the wrapped or saturated value.
- With the prescaler, the first step after enable or load happens PRESCALE enabled cycles later.
- There is no combinational path from inputs to outputs.

## Configuration

- Macro: `COUNTER_PRESCALER_EN`.
- When defined, an internal prescaler of width clog2(PRESCALE) counts enabled cycles. It produces a tick when it reaches PRESCALE-1 and then returns to 0. It holds when `en`=0, and clears on `load` and `rst`. When PRESCALE=1 the tick is true every enabled cycle.
- When undefined, no prescaler logic is built, PRESCALE is ignored, and the counter steps on every enabled cycle.

## Test plan

Configuration for these tests: WIDTH=4, MAX_VAL=9, prescaler off unless stated otherwise.

- Reset: assert `rst` asynchronously at count 5 -> `count`=0, `tc`=0 and `ovf`=0 immediately, without waiting for a clock edge.
- Up wrap: `en`=1, `up_dn`=1, `sat_mode`=0, starting at 0, run 12 cycles -> `count` sequence is 1..9,0,1,2; `tc` is high only in the cycle `count`=0; `ovf`=1 from then on.
- Down saturate: load 1, then `up_dn`=0, `sat_mode`=1, run 3 cycles -> `count` is 0,0,0; `tc` is high on the second and third cycles; `ovf`=1.
- Load clamp and priority: `load`=1 with `load_val`=14 and `en`=1 -> `count`=9 and `tc`=0. Then hold `en`=0 for 3 cycles -> `count` stays at 9.
- Overflow clear: with `ovf`=1, pulse `clear_ovf` -> `ovf`=0. Then assert `clear_ovf` in the same cycle as an up-wrap from 9 -> `ovf`=1, because set wins.
- Prescaler: with `COUNTER_PRESCALER_EN` defined and PRESCALE=3, `en`=1 from count 0 for 9 cycles -> `count` reaches 1, 2, 3 on cycles 3, 6 and 9. Dropping `en` for 2 cycles mid-period delays the next step by 2 cycles.

Source files
------------

// File: rtl/counter_param.sv
// -----------------------------------------------------------------------------
// counter_param
//
// Parametrised up/down counter with synchronous load, wrap or saturate
// behaviour at the range limits, a registered terminal-count pulse and a
// sticky overflow/underflow flag. The range is 0..MAX_VAL.
//
// Optional feature macro: COUNTER_PRESCALER_EN
//   When defined, an internal prescaler makes the counter step once every
//   PRESCALE enabled clock cycles. When undefined, no prescaler is built and
//   the counter steps on every enabled cycle.
//
// Parameters:
//   WIDTH     counter width in bits (>= 2)
//   MAX_VAL   top count value (<= 2**WIDTH-1)
//   PRESCALE  enabled cycles per count step (>= 1), prescaler builds only
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   count enable; the counter holds when low
//   up_dn      in   1 = count up, 0 = count down
//   sat_mode   in   1 = saturate at the limits, 0 = wrap
//   load       in   synchronous load strobe (takes priority over stepping)
//   load_val   in   load value, clamped to MAX_VAL
//   clear_ovf  in   clears the sticky ovf flag (a same-cycle set wins)
//   count      out  current count, registered
//   tc         out  one-cycle terminal-count pulse, registered
//   ovf        out  sticky overflow/underflow flag, registered
// -----------------------------------------------------------------------------
module counter_param #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             tc_r;
    logic             tc_nxt_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             tick_s;
    logic             step_s;

`ifdef COUNTER_PRESCALER_EN
    // A PRESCALE of 1 would give a zero-width counter; keep one bit, which
    // then sits at 0 and makes the tick true on every enabled cycle.
    localparam int              PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST_C = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ZERO_C = PS_W'(0);
    localparam logic [PS_W-1:0] PS_ONE_C  = PS_W'(1);

    logic [PS_W-1:0] ps_r;
    logic [PS_W-1:0] ps_nxt_s;

    assign tick_s = (ps_r == PS_LAST_C);

    // Prescaler next state: clear on load, advance and roll over on enabled cycles.
    always_comb begin
        ps_nxt_s = ps_r;
        if (load) begin
            ps_nxt_s = PS_ZERO_C;
        end else if (en) begin
            if (tick_s) begin
                ps_nxt_s = PS_ZERO_C;
            end else begin
                ps_nxt_s = ps_r + PS_ONE_C;
            end
        end else begin
            ps_nxt_s = ps_r;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_r <= PS_ZERO_C;
        end else begin
            ps_r <= ps_nxt_s;
        end
    end
`else
    // Without a prescaler every enabled cycle is a step; PRESCALE is inert.
    logic unused_prescale_s;
    assign unused_prescale_s = (PRESCALE > 0);
    assign tick_s            = 1'b1;
`endif

    assign step_s = en & ~load & tick_s;

    // Counter next state: load beats step beats hold; boundary steps pulse tc and set ovf.
    always_comb begin
        count_nxt_s = count_r;
        tc_nxt_s    = 1'b0;
        // A set later in this block overrides the clear, so set wins.
        ovf_nxt_s   = ovf_r & ~clear_ovf;
        if (load) begin
            if (load_val > MAX_C) begin
                count_nxt_s = MAX_C;
            end else begin
                count_nxt_s = load_val;
            end
        end else if (step_s) begin
            if (up_dn) begin
                // >= rather than == keeps the boundary test safe even though
                // values above MAX_VAL are unreachable.
                if (count_r >= MAX_C) begin
                    tc_nxt_s    = 1'b1;
                    ovf_nxt_s   = 1'b1;
                    count_nxt_s = sat_mode ? MAX_C : ZERO_C;
                end else begin
                    count_nxt_s = count_r + ONE_C;
                end
            end else begin
                if (count_r == ZERO_C) begin
                    tc_nxt_s    = 1'b1;
                    ovf_nxt_s   = 1'b1;
                    count_nxt_s = sat_mode ? ZERO_C : MAX_C;
                end else begin
                    count_nxt_s = count_r - ONE_C;
                end
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= ZERO_C;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            tc_r    <= tc_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    assign count = count_r;
    assign tc    = tc_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_counter_param.sv
// -----------------------------------------------------------------------------
// tb_counter_param
//
// Scoreboard bench for counter_param (WIDTH=4, MAX_VAL=9). The stimulus
// process drives directed vectors and pushes the hand-computed expected
// {count, tc, ovf} for each clock edge into a queue; a separate monitor pops
// and compares on the falling edge. The asynchronous reset is checked directly
// between clock edges. With COUNTER_PRESCALER_EN defined, the prescaler
// sequence (PRESCALE=3) is run instead of the default sequence.
// -----------------------------------------------------------------------------
module tb_counter_param;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       en        = 1'b0;
    logic       up_dn     = 1'b1;
    logic       sat_mode  = 1'b0;
    logic       load      = 1'b0;
    logic [3:0] load_val  = 4'd0;
    logic       clear_ovf = 1'b0;
    logic [3:0] count;
    logic       tc;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int step_id  = 0;

    logic [5:0] exp_q[$];
    int         id_q[$];

    counter_param #(
        .WIDTH    (4),
        .MAX_VAL  (9),
        .PRESCALE (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .sat_mode  (sat_mode),
        .load      (load),
        .load_val  (load_val),
        .clear_ovf (clear_ovf),
        .count     (count),
        .tc        (tc),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int id,
                         input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got count=%0d tc=%0b ovf=%0b, expected count=%0d tc=%0b ovf=%0b",
                     name, id, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // One clock edge with the inputs currently applied; queue what should follow it.
    task automatic cyc(input logic [3:0] e_cnt, input logic e_tc, input logic e_ovf);
        @(posedge clk);
        #1;
        exp_q.push_back({e_cnt, e_tc, e_ovf});
        id_q.push_back(step_id);
        step_id++;
    endtask

    task automatic set_in(input logic i_en, input logic i_up, input logic i_sat,
                          input logic i_load, input logic [3:0] i_val, input logic i_clr);
        en        = i_en;
        up_dn     = i_up;
        sat_mode  = i_sat;
        load      = i_load;
        load_val  = i_val;
        clear_ovf = i_clr;
    endtask

    // Monitor: compare the registered outputs against the oldest expectation.
    always @(negedge clk) begin
        logic [5:0] e;
        int         id;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            check("step", id, {count, tc, ovf}, e);
        end
    end

    initial begin
        // Reset held across edges.
        cyc(4'd0, 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0);
        rst = 1'b0;

`ifdef COUNTER_PRESCALER_EN
        // PRESCALE=3: steps land on every third enabled cycle.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0);
        cyc(4'd1, 1'b0, 1'b0);
        cyc(4'd1, 1'b0, 1'b0);
        cyc(4'd1, 1'b0, 1'b0);
        cyc(4'd2, 1'b0, 1'b0);
        cyc(4'd2, 1'b0, 1'b0);
        cyc(4'd2, 1'b0, 1'b0);
        cyc(4'd3, 1'b0, 1'b0);
        cyc(4'd3, 1'b0, 1'b0);          // prescaler now 1
        en = 1'b0;
        cyc(4'd3, 1'b0, 1'b0);
        cyc(4'd3, 1'b0, 1'b0);
        en = 1'b1;
        cyc(4'd3, 1'b0, 1'b0);          // prescaler 2
        cyc(4'd4, 1'b0, 1'b0);
        // Load clears the prescaler: next step three cycles later.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0);
        cyc(4'd7, 1'b0, 1'b0);
        load = 1'b0;
        cyc(4'd7, 1'b0, 1'b0);
        cyc(4'd7, 1'b0, 1'b0);
        cyc(4'd8, 1'b0, 1'b0);
`else
        // Up wrap from 0 over 12 cycles.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            cyc(4'(i), 1'b0, 1'b0);
        end
        cyc(4'd0, 1'b1, 1'b1);
        cyc(4'd1, 1'b0, 1'b1);
        cyc(4'd2, 1'b0, 1'b1);

        // Load 5, then asynchronous reset between edges.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
        cyc(4'd5, 1'b0, 1'b1);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst", 0, {count, tc, ovf}, 6'b0000_0_0);
        #2;
        rst = 1'b0;

        // Down saturate from 1.
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
        cyc(4'd1, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0);
        cyc(4'd0, 1'b1, 1'b1);
        cyc(4'd0, 1'b1, 1'b1);

        // Load clamp with en high, then hold.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd14, 1'b0);
        cyc(4'd9, 1'b0, 1'b1);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(4'd9, 1'b0, 1'b1);
        cyc(4'd9, 1'b0, 1'b1);
        cyc(4'd9, 1'b0, 1'b1);

        // Overflow clear, then clear coinciding with a wrap (set wins).
        clear_ovf = 1'b1;
        cyc(4'd9, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        cyc(4'd0, 1'b1, 1'b1);
        clear_ovf = 1'b0;
        cyc(4'd1, 1'b0, 1'b1);

        // Up saturate at MAX_VAL with repeated tc.
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 4'd8, 1'b0);
        cyc(4'd8, 1'b0, 1'b1);
        load = 1'b0;
        cyc(4'd9, 1'b0, 1'b1);
        cyc(4'd9, 1'b1, 1'b1);
        cyc(4'd9, 1'b1, 1'b1);

        // Direction change between steps, down wrap from 0.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(4'd8, 1'b0, 1'b1);
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        cyc(4'd0, 1'b0, 1'b1);
        load = 1'b0;
        cyc(4'd9, 1'b1, 1'b1);
        up_dn = 1'b1;
        cyc(4'd0, 1'b1, 1'b1);

        // Load together with clear_ovf.
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1);
        cyc(4'd3, 1'b0, 1'b0);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(4'd3, 1'b0, 1'b0);
`endif

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
